// File: rtl/countdown_timer.sv
// Loadable down-counting timer with one-shot/periodic expiry, valid/ready load and sticky flag.
// Optional tick prescaler is built only when TIMER_PRESCALE_EN is defined.
module countdown_timer #(
    parameter int WIDTH          = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_valid_i,
    output logic                      load_ready_o,
    input  logic [WIDTH-1:0]          load_value_i,
    input  logic                      periodic_i,
    input  logic [PRESCALE_WIDTH-1:0] prescale_i,
    input  logic                      stop_i,
    input  logic                      clear_i,
    output logic [WIDTH-1:0]          count_o,
    output logic                      busy_o,
    output logic                      expire_o,
    output logic                      expired_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nx;
    logic [WIDTH-1:0]   r_count;
    logic [WIDTH-1:0]   w_count_nx;
    logic [WIDTH-1:0]   r_reload;
    logic [WIDTH-1:0]   w_reload_nx;
    logic               r_periodic;
    logic               w_periodic_nx;
    logic               r_expire;
    logic               w_expire_nx;
    logic               r_expired;
    logic               w_expired_nx;
    logic               r_zero_pend;
    logic               w_zero_pend_nx;
    logic               w_accept;
    logic               w_tick;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_WIDTH-1:0] r_presc_cnt;
    logic [PRESCALE_WIDTH-1:0] w_presc_cnt_nx;
    logic [PRESCALE_WIDTH-1:0] r_presc_div;
    logic [PRESCALE_WIDTH-1:0] w_presc_div_nx;

    assign w_tick = (r_presc_cnt == r_presc_div);
`else
    logic w_unused_prescale;

    assign w_unused_prescale = ^prescale_i;
    assign w_tick            = 1'b1;
`endif

    assign w_accept     = load_valid_i && (r_state == ST_IDLE);
    assign load_ready_o = (r_state == ST_IDLE);
    assign busy_o       = (r_state == ST_RUN);
    assign count_o      = r_count;
    assign expire_o     = r_expire;
    assign expired_o    = r_expired;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= {WIDTH{1'b0}};
            r_reload    <= {WIDTH{1'b0}};
            r_periodic  <= 1'b0;
            r_expire    <= 1'b0;
            r_expired   <= 1'b0;
            r_zero_pend <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            r_presc_cnt <= {PRESCALE_WIDTH{1'b0}};
            r_presc_div <= {PRESCALE_WIDTH{1'b0}};
`endif
        end else begin
            r_state     <= w_state_nx;
            r_count     <= w_count_nx;
            r_reload    <= w_reload_nx;
            r_periodic  <= w_periodic_nx;
            r_expire    <= w_expire_nx;
            r_expired   <= w_expired_nx;
            r_zero_pend <= w_zero_pend_nx;
`ifdef TIMER_PRESCALE_EN
            r_presc_cnt <= w_presc_cnt_nx;
            r_presc_div <= w_presc_div_nx;
`endif
        end
    end

    // Next-state, count, reload and expiry decode.
    always_comb begin
        w_state_nx     = r_state;
        w_count_nx     = r_count;
        w_reload_nx    = r_reload;
        w_periodic_nx  = r_periodic;
        w_zero_pend_nx = 1'b0;
        // A zero-length load expires one edge after the accept.
        w_expire_nx    = r_zero_pend;
`ifdef TIMER_PRESCALE_EN
        w_presc_cnt_nx = r_presc_cnt;
        w_presc_div_nx = r_presc_div;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_count_nx    = load_value_i;
                    w_reload_nx   = load_value_i;
                    w_periodic_nx = periodic_i;
`ifdef TIMER_PRESCALE_EN
                    w_presc_cnt_nx = {PRESCALE_WIDTH{1'b0}};
                    w_presc_div_nx = prescale_i;
`endif
                    if (load_value_i != {WIDTH{1'b0}}) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_zero_pend_nx = 1'b1;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_state_nx = ST_IDLE;
                    w_count_nx = {WIDTH{1'b0}};
                end else if (w_tick) begin
`ifdef TIMER_PRESCALE_EN
                    w_presc_cnt_nx = {PRESCALE_WIDTH{1'b0}};
`endif
                    if (r_count == WIDTH'(1'b1)) begin
                        w_expire_nx = 1'b1;
                        if (r_periodic) begin
                            w_count_nx = r_reload;
                        end else begin
                            w_count_nx = {WIDTH{1'b0}};
                            w_state_nx = ST_IDLE;
                        end
                    end else if (r_count != {WIDTH{1'b0}}) begin
                        w_count_nx = r_count - WIDTH'(1'b1);
                    end else begin
                        w_count_nx = {WIDTH{1'b0}};
                    end
                end else begin
`ifdef TIMER_PRESCALE_EN
                    w_presc_cnt_nx = r_presc_cnt + PRESCALE_WIDTH'(1'b1);
`endif
                    w_count_nx = r_count;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_count_nx = {WIDTH{1'b0}};
            end
        endcase
    end

    // Sticky flag: a new expiry takes priority over clear.
    always_comb begin
        w_expired_nx = r_expired;
        if (w_expire_nx) begin
            w_expired_nx = 1'b1;
        end else if (clear_i) begin
            w_expired_nx = 1'b0;
        end else begin
            w_expired_nx = r_expired;
        end
    end

endmodule
